bp_fe_btb_update_queue: RTL and testbench

- Small FIFO between the FE redirect/training logic and the BTB synchronous write port.
- Captures branch-site/target training updates with a ready/valid handshake.
- Splits each branch-site address into BTB index and tag.
- Presents the oldest update to the BTB and retires it only on the BTB's yumi. The BTB can refuse a write on a read/write index collision or during init, so updates are not lost.
- Coalesces back-to-back updates to the same BTB index so stale training never lands after fresh training.

---
 rtl/bp_fe_btb_update_queue.sv | 150 +++++++++++++++
 tb/tb_bp_fe_btb_update_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_btb_update_queue.sv
// Purpose: small update queue in front of the BTB write port. It coalesces same-index updates behind the head.
// Latency: an update enqueued at edge N shows on w_v_o in cycle N+1. There is no combinational bypass.
// Backpressure: upd_ready_o drops when the queue is full. The head is retired only on w_yumi_i.
//
// Ports:
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   flush_i                  drops every queued update (wins over enqueue/dequeue)
//   btb_init_done_i          gates w_v_o while the BTB is still clearing
//   upd_*                    training update in (valid/ready), site sliced into idx/tag on entry
//   w_*                      head entry toward the BTB write port, w_yumi_i retires it
//   count_o                  occupancy 0..els_p
module bp_fe_btb_update_queue #(
    parameter int vaddr_width_p   = 39,
    parameter int btb_idx_width_p = 6,
    parameter int btb_tag_width_p = 10,
    parameter int els_p           = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         flush_i,
    input  logic                         btb_init_done_i,
    input  logic                         upd_v_i,
    output logic                         upd_ready_o,
    input  logic                         upd_clr_i,
    input  logic                         upd_jmp_i,
    input  logic [vaddr_width_p-1:0]     upd_site_i,
    input  logic [vaddr_width_p-1:0]     upd_tgt_i,
    output logic                         w_v_o,
    output logic                         w_clr_o,
    output logic                         w_jmp_o,
    output logic [btb_tag_width_p-1:0]   w_tag_o,
    output logic [btb_idx_width_p-1:0]   w_idx_o,
    output logic [vaddr_width_p-1:0]     w_tgt_o,
    input  logic                         w_yumi_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] two_cnt_lp  = cnt_w_lp'(2);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);

    typedef struct packed {
        logic                       clr;
        logic                       jmp;
        logic [btb_tag_width_p-1:0] tag;
        logic [btb_idx_width_p-1:0] idx;
        logic [vaddr_width_p-1:0]   tgt;
    } entry_t;

    entry_t                mem_q [els_p];
    entry_t                mem_d [els_p];
    logic [ptr_w_lp-1:0]   head_q, head_d;
    logic [ptr_w_lp-1:0]   tail_q, tail_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;

    entry_t                upd_entry;
    entry_t                head_entry;
    logic [ptr_w_lp-1:0]   tail_last;
    logic                  enq, deq, coalesce, push;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + 1'b1;
    endfunction

    // Site bits below the word offset and above the tag are never stored.
    logic unused_site_bits;
    assign unused_site_bits = ^{upd_site_i[1:0],
                                upd_site_i[vaddr_width_p-1:2+btb_idx_width_p+btb_tag_width_p]};

    assign upd_entry.clr = upd_clr_i;
    assign upd_entry.jmp = upd_jmp_i;
    assign upd_entry.tag = upd_site_i[2+btb_idx_width_p +: btb_tag_width_p];
    assign upd_entry.idx = upd_site_i[2 +: btb_idx_width_p];
    assign upd_entry.tgt = upd_tgt_i;

    assign head_entry  = mem_q[head_q];
    assign tail_last   = (tail_q == '0) ? last_ptr_lp : tail_q - 1'b1;

    // Ready depends only on registered occupancy, so a full queue stays
    // unready even in a cycle where the head retires.
    assign upd_ready_o = (count_q != full_cnt_lp);
    assign w_v_o       = (count_q != '0) & btb_init_done_i;
    assign w_clr_o     = head_entry.clr;
    assign w_jmp_o     = head_entry.jmp;
    assign w_tag_o     = head_entry.tag;
    assign w_idx_o     = head_entry.idx;
    assign w_tgt_o     = head_entry.tgt;
    assign count_o     = count_q;

    assign enq = upd_v_i & upd_ready_o;
    // Gated on occupancy so an illegal yumi cannot wrap the counter.
    assign deq = w_yumi_i & (count_q != '0);
    // With two or more entries the tail-most one is never the head, so
    // overwriting it cannot disturb data the BTB may be sampling.
    assign coalesce = enq & (count_q >= two_cnt_lp) & (mem_q[tail_last].idx == upd_entry.idx);
    assign push     = enq & ~coalesce;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (coalesce) begin
                mem_d[tail_last] = upd_entry;
            end else if (push) begin
                mem_d[tail_q] = upd_entry;
                tail_d        = ptr_inc(tail_q);
            end
            if (deq) begin
                head_d = ptr_inc(head_q);
            end
            unique case ({push, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < els_p; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        w_yumi_i |-> w_v_o);
    a_count_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        count_q <= full_cnt_lp);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (count_q == '0) |-> !w_yumi_i);

endmodule

// File: tb/tb_bp_fe_btb_update_queue.sv
module tb_bp_fe_btb_update_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        init_done;
    logic        upd_v;
    logic        upd_ready;
    logic        upd_clr;
    logic        upd_jmp;
    logic [38:0] upd_site;
    logic [38:0] upd_tgt;
    logic        w_v;
    logic        w_clr;
    logic        w_jmp;
    logic [9:0]  w_tag;
    logic [5:0]  w_idx;
    logic [38:0] w_tgt;
    logic        w_yumi;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        clr;
        logic        jmp;
        logic [9:0]  tag;
        logic [5:0]  idx;
        logic [38:0] tgt;
    } wr_t;

    wr_t exp_q[$];

    always #5 clk = ~clk;

    bp_fe_btb_update_queue dut (
        .clk_i           (clk),
        .reset_n_i       (rst_n),
        .flush_i         (flush),
        .btb_init_done_i (init_done),
        .upd_v_i         (upd_v),
        .upd_ready_o     (upd_ready),
        .upd_clr_i       (upd_clr),
        .upd_jmp_i       (upd_jmp),
        .upd_site_i      (upd_site),
        .upd_tgt_i       (upd_tgt),
        .w_v_o           (w_v),
        .w_clr_o         (w_clr),
        .w_jmp_o         (w_jmp),
        .w_tag_o         (w_tag),
        .w_idx_o         (w_idx),
        .w_tgt_o         (w_tgt),
        .w_yumi_i        (w_yumi),
        .count_o         (count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [38:0] mk_site(input logic [9:0] tag, input logic [5:0] idx);
        return {21'b0, tag, idx, 2'b00};
    endfunction

    task automatic push(input logic clr, input logic jmp, input logic [9:0] tag,
                        input logic [5:0] idx, input logic [38:0] tgt);
        wr_t e;
        e.clr = clr; e.jmp = jmp; e.tag = tag; e.idx = idx; e.tgt = tgt;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic clr, input logic jmp, input logic [38:0] site, input logic [38:0] tgt);
        upd_v = 1'b1; upd_clr = clr; upd_jmp = jmp; upd_site = site; upd_tgt = tgt;
        step();
        upd_v = 1'b0; upd_clr = 1'b0; upd_jmp = 1'b0;
    endtask

    task automatic yumi1();
        w_yumi = 1'b1;
        step();
        w_yumi = 1'b0;
    endtask

    // Scoreboard monitor: every accepted BTB write must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && w_v && w_yumi) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got idx=%0h tgt=%0h expected no write", w_idx, w_tgt);
            end else begin
                wr_t e;
                wr_t a;
                e = exp_q.pop_front();
                a = {w_clr, w_jmp, w_tag, w_idx, w_tgt};
                if (a !== e) begin
                    bad++;
                    $display("FAIL wr_data: got clr=%0b jmp=%0b tag=%0h idx=%0h tgt=%0h expected clr=%0b jmp=%0b tag=%0h idx=%0h tgt=%0h",
                             a.clr, a.jmp, a.tag, a.idx, a.tgt, e.clr, e.jmp, e.tag, e.idx, e.tgt);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; flush = 1'b0; init_done = 1'b1; upd_v = 1'b0; upd_clr = 1'b0;
        upd_jmp = 1'b0; upd_site = '0; upd_tgt = '0; w_yumi = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_count", count, 0);
        chk("rst_ready", upd_ready, 1);
        chk("rst_wv", w_v, 0);
        step(); step();
        #2 rst_n = 1'b1;
        step();

        // Basic pass-through: site 0x1010 -> idx 4, tag 0x10.
        upd_v = 1'b1; upd_jmp = 1'b1; upd_site = 39'h1010; upd_tgt = 39'h2000;
        chk("t2_no_bypass", w_v, 0);
        push(1'b0, 1'b1, 10'h010, 6'd4, 39'h2000);
        step();
        upd_v = 1'b0; upd_jmp = 1'b0;
        chk("t2_wv", w_v, 1);
        chk("t2_idx", w_idx, 4);
        chk("t2_count", count, 1);
        yumi1();
        chk("t2_empty_count", count, 0);
        chk("t2_empty_wv", w_v, 0);

        // Fill with the BTB refusing, then retire one.
        for (int i = 0; i < 4; i++) begin
            enq(1'b0, 1'b0, mk_site(10'(i + 1), 6'(i)), 39'h100 + 39'(i));
            push(1'b0, 1'b0, 10'(i + 1), 6'(i), 39'h100 + 39'(i));
        end
        chk("t3_full_count", count, 4);
        chk("t3_full_ready", upd_ready, 0);
        upd_v = 1'b1; upd_site = mk_site(10'd9, 6'd20); upd_tgt = 39'h999;
        step();
        chk("t3_fifth_dropped", count, 4);
        w_yumi = 1'b1;
        chk("t3_full_yumi_ready", upd_ready, 0);
        step();
        w_yumi = 1'b0; upd_v = 1'b0;
        chk("t3_after_yumi_count", count, 3);
        chk("t3_after_yumi_ready", upd_ready, 1);
        chk("t3_head_second", w_idx, 1);
        yumi1(); yumi1(); yumi1();
        chk("t3_drained", count, 0);

        // Coalescing behind the head.
        enq(1'b0, 1'b0, mk_site(10'd2, 6'd1), 39'h1000);
        enq(1'b0, 1'b0, mk_site(10'd3, 6'd5), 39'h2000);
        enq(1'b0, 1'b1, mk_site(10'd4, 6'd5), 39'h3000);
        chk("t4_coalesce_count", count, 2);
        push(1'b0, 1'b0, 10'd2, 6'd1, 39'h1000);
        push(1'b0, 1'b1, 10'd4, 6'd5, 39'h3000);
        yumi1(); yumi1();
        chk("t4_drained", count, 0);
        // Same index as the head with one entry: no coalesce.
        enq(1'b0, 1'b0, mk_site(10'd5, 6'd7), 39'h5000);
        enq(1'b1, 1'b0, mk_site(10'd6, 6'd7), 39'h6000);
        chk("t4_head_no_coalesce", count, 2);
        push(1'b0, 1'b0, 10'd5, 6'd7, 39'h5000);
        push(1'b1, 1'b0, 10'd6, 6'd7, 39'h6000);
        yumi1(); yumi1();
        // Coalesce and dequeue in the same cycle.
        enq(1'b0, 1'b0, mk_site(10'd1, 6'd1), 39'h7000);
        enq(1'b0, 1'b0, mk_site(10'd1, 6'd2), 39'h7100);
        push(1'b0, 1'b0, 10'd1, 6'd1, 39'h7000);
        push(1'b0, 1'b0, 10'd1, 6'd2, 39'h7200);
        upd_v = 1'b1; upd_site = mk_site(10'd1, 6'd2); upd_tgt = 39'h7200; w_yumi = 1'b1;
        step();
        upd_v = 1'b0; w_yumi = 1'b0;
        chk("t4_coal_deq_count", count, 1);
        chk("t4_coal_deq_tgt", w_tgt, 39'h7200);
        yumi1();
        chk("t4_final", count, 0);

        // Init gating.
        init_done = 1'b0;
        enq(1'b0, 1'b0, mk_site(10'd7, 6'd9), 39'h8000);
        enq(1'b0, 1'b1, mk_site(10'd7, 6'd10), 39'h8100);
        chk("t5_gated_wv", w_v, 0);
        chk("t5_gated_count", count, 2);
        push(1'b0, 1'b0, 10'd7, 6'd9, 39'h8000);
        push(1'b0, 1'b1, 10'd7, 6'd10, 39'h8100);
        #2 init_done = 1'b1;
        #1;
        chk("t5_init_wv", w_v, 1);
        chk("t5_init_idx", w_idx, 9);
        step();
        yumi1(); yumi1();

        // Streaming enqueue+yumi so both pointers wrap several times.
        enq(1'b0, 1'b0, mk_site(10'd0, 6'd16), 39'h4000);
        push(1'b0, 1'b0, 10'd0, 6'd16, 39'h4000);
        for (int i = 1; i < 10; i++) begin
            upd_v = 1'b1; upd_site = mk_site(10'd0, 6'(16 + i)); upd_tgt = 39'h4000 + 39'(i);
            w_yumi = 1'b1;
            push(1'b0, 1'b0, 10'd0, 6'(16 + i), 39'h4000 + 39'(i));
            step();
            chk("t6_count_steady", count, 1);
        end
        upd_v = 1'b0; w_yumi = 1'b0;
        yumi1();
        chk("t6_wrap_empty", count, 0);
        // Flush beats a same-cycle enqueue and yumi; the yumi'd write itself still happens.
        enq(1'b0, 1'b0, mk_site(10'd3, 6'd40), 39'h4040);
        push(1'b0, 1'b0, 10'd3, 6'd40, 39'h4040);
        upd_v = 1'b1; upd_site = mk_site(10'd3, 6'd41); upd_tgt = 39'h4141;
        flush = 1'b1; w_yumi = 1'b1;
        step();
        upd_v = 1'b0; flush = 1'b0; w_yumi = 1'b0;
        chk("t6_flush_count", count, 0);
        chk("t6_flush_wv", w_v, 0);
        chk("t6_flush_ready", upd_ready, 1);
        step();
        chk("t6_flush_dropped", count, 0);
        enq(1'b0, 1'b1, mk_site(10'd3, 6'd42), 39'h4242);
        chk("t6_post_flush_idx", w_idx, 42);
        push(1'b0, 1'b1, 10'd3, 6'd42, 39'h4242);
        yumi1();
        chk("t6_post_flush_empty", count, 0);

        // Reset in the middle of a run with three entries queued.
        for (int i = 0; i < 3; i++) begin
            enq(1'b0, 1'b0, mk_site(10'd8, 6'(50 + i)), 39'h5100 + 39'(i));
            push(1'b0, 1'b0, 10'd8, 6'(50 + i), 39'h5100 + 39'(i));
        end
        chk("t1_pre_count", count, 3);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t1_async_count", count, 0);
        chk("t1_async_wv", w_v, 0);
        chk("t1_async_ready", upd_ready, 1);
        chk("t1_async_idx", w_idx, 0);
        step();
        #2 rst_n = 1'b1;
        step();
        chk("t1_count", count, 0);
        chk("t1_wv", w_v, 0);
        chk("t1_ready", upd_ready, 1);
        chk("t1_idx", w_idx, 0);
        chk("t1_tgt", w_tgt, 0);

        repeat (3) step();
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
